// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : UART transmitter fed by a byte FIFO. A programmable baud-tick
//             generator paces a frame FSM (start / 5..8 data / optional
//             parity / 1, 1.5 or 2 stop bits). Each bit lasts OVS ticks.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   rising-edge clock
//    rst           in   asynchronous active-high reset
//    divisor       in   clk cycles per baud tick (0 halts the tick generator)
//    wr_en         in   push wr_data into the FIFO
//    wr_data       in   byte to transmit
//    wls           in   word length, 00..11 = 5..8 data bits
//    pen           in   parity enable
//    eps           in   even parity select
//    stick_parity  in   stick parity (parity bit = ~eps)
//    stb           in   extra stop bits (1.5 for 5-bit words, else 2)
//    set_break     in   force the line low
//    full          out  FIFO full
//    thre          out  FIFO empty
//    level         out  FIFO occupancy
//    ovf           out  one-cycle pulse when a write is dropped
//    tsre          out  FIFO empty and transmitter idle
//    tx            out  serial line
// ============================================================================
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16,
    parameter int OVS        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              divisor,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  logic [1:0]                    wls,
    input  logic                          pen,
    input  logic                          eps,
    input  logic                          stick_parity,
    input  logic                          stb,
    input  logic                          set_break,
    output logic                          full,
    output logic                          thre,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          ovf,
    output logic                          tsre,
    output logic                          tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    // Tick counter must reach 2*OVS-1 for the longest stop bit.
    localparam int TW = $clog2(2 * OVS) + 1;

    localparam logic [TW-1:0] c_BIT_LAST    = TW'(OVS - 1);
    localparam logic [TW-1:0] c_STOP15_LAST = TW'((3 * OVS) / 2 - 1);
    localparam logic [TW-1:0] c_STOP2_LAST  = TW'(2 * OVS - 1);
    localparam logic [AW:0]   c_DEPTH       = (AW + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Baud tick generator
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] baud_cnt_q;
    logic             w_tick;

    // The counter only samples divisor when it reloads, so a divisor change
    // never cuts the count in progress short.
    assign w_tick = (divisor != '0) && (baud_cnt_q <= DIV_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt_q <= '0;
        end else if (divisor == '0) begin
            baud_cnt_q <= '0;
        end else if (w_tick) begin
            baud_cnt_q <= divisor;
        end else begin
            baud_cnt_q <= baud_cnt_q - DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   level_q;
    logic          ovf_q;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_head;

    assign full  = (level_q == c_DEPTH);
    assign thre  = (level_q == '0);
    assign level = level_q;
    assign ovf   = ovf_q;

    // A pop in the same cycle frees a slot, so a write into a full FIFO is
    // still accepted then.
    assign w_push = wr_en && (!full || w_pop);
    assign w_head = mem_q[rptr_q];

    // Storage carries no reset; clearing the pointers discards the contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= wr_en && full && !w_pop;
            if (w_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (w_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   level_q <= level_q + (AW + 1)'(1);
                2'b01:   level_q <= level_q - (AW + 1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t        state_q;
    logic [TW-1:0] tcnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          par_q;      // XOR of the data bits of the current frame
    logic [1:0]    f_wls_q;
    logic          f_pen_q;
    logic          f_eps_q;
    logic          f_stick_q;
    logic          f_stb_q;
    logic          tx_q;

    logic [TW-1:0] w_stop_last;
    logic [7:0]    w_mask;
    logic [7:0]    w_load;
    logic [2:0]    w_data_last;
    logic          w_par_bit;

    assign w_stop_last = !f_stb_q            ? c_BIT_LAST    :
                         (f_wls_q == 2'b00)  ? c_STOP15_LAST : c_STOP2_LAST;

    // A new frame starts from IDLE, or straight out of the final stop tick
    // so consecutive frames carry no idle gap.
    assign w_pop = !thre && w_tick &&
                   ((state_q == S_IDLE) ||
                    ((state_q == S_STOP) && (tcnt_q == w_stop_last)));

    // Bits above the word length are cleared so they neither go out nor
    // contribute to parity.
    assign w_mask      = 8'hFF >> (2'd3 - wls);
    assign w_load      = w_head & w_mask;
    assign w_data_last = {1'b0, f_wls_q} + 3'd4;
    assign w_par_bit   = f_stick_q ? ~f_eps_q : (f_eps_q ? par_q : ~par_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tcnt_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            f_wls_q   <= '0;
            f_pen_q   <= 1'b0;
            f_eps_q   <= 1'b0;
            f_stick_q <= 1'b0;
            f_stb_q   <= 1'b0;
            tx_q      <= 1'b1;
        end else if (w_tick) begin
            case (state_q)
                S_IDLE: begin
                    tcnt_q <= '0;
                    if (!thre) begin
                        state_q <= S_START;
                        tx_q    <= 1'b0;
                    end
                end

                S_START: begin
                    if (tcnt_q == c_BIT_LAST) begin
                        state_q <= S_DATA;
                        tcnt_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end

                S_DATA: begin
                    if (tcnt_q == c_BIT_LAST) begin
                        tcnt_q <= '0;
                        if (bit_q == w_data_last) begin
                            if (f_pen_q) begin
                                state_q <= S_PARITY;
                                tx_q    <= w_par_bit;
                            end else begin
                                state_q <= S_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end

                S_PARITY: begin
                    if (tcnt_q == c_BIT_LAST) begin
                        state_q <= S_STOP;
                        tcnt_q  <= '0;
                        tx_q    <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end

                S_STOP: begin
                    if (tcnt_q == w_stop_last) begin
                        tcnt_q <= '0;
                        if (!thre) begin
                            state_q <= S_START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    tcnt_q  <= '0;
                    tx_q    <= 1'b1;
                end
            endcase

            // Frame configuration is captured once per frame and held.
            if (w_pop) begin
                shift_q   <= w_load;
                par_q     <= ^w_load;
                f_wls_q   <= wls;
                f_pen_q   <= pen;
                f_eps_q   <= eps;
                f_stick_q <= stick_parity;
                f_stb_q   <= stb;
            end
        end
    end

    assign tsre = thre && (state_q == S_IDLE);

    // Break only gates the registered line; the FSM keeps running underneath.
    assign tx = tx_q & ~set_break;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Purpose  : Self-checking bench for uart_tx_fifo. A table of frame
//             vectors with hand-computed bit sequences, plus directed
//             sequences for overflow/back-to-back, break and mid-frame reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int FIFO_DEPTH = 16;
    localparam int DIV_W      = 16;
    localparam int OVS        = 16;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [DIV_W-1:0]            divisor = '0;
    logic                        wr_en = 1'b0;
    logic [7:0]                  wr_data = '0;
    logic [1:0]                  wls = 2'b11;
    logic                        pen = 1'b0;
    logic                        eps = 1'b0;
    logic                        stick_parity = 1'b0;
    logic                        stb = 1'b0;
    logic                        set_break = 1'b0;
    logic                        full;
    logic                        thre;
    logic [$clog2(FIFO_DEPTH):0] level;
    logic                        ovf;
    logic                        tsre;
    logic                        tx;

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_W      (DIV_W),
        .OVS        (OVS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .divisor      (divisor),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wls          (wls),
        .pen          (pen),
        .eps          (eps),
        .stick_parity (stick_parity),
        .stb          (stb),
        .set_break    (set_break),
        .full         (full),
        .thre         (thre),
        .level        (level),
        .ovf          (ovf),
        .tsre         (tsre),
        .tx           (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [1:0]  wls;
        logic        pen;
        logic        eps;
        logic        stick;
        logic        stb;
        logic [7:0]  data;
        int          nbits;       // start + data + parity bits
        logic [11:0] bits;        // bit k = k-th bit on the line (start = bit 0)
        int          stop_ticks;
    } frame_vec_t;

    frame_vec_t vecs [7];

    int n_checks = 0;
    int n_fail   = 0;
    int cur_off  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic goto_off(input int t);
        while (cur_off < t) begin
            @(negedge clk);
            cur_off++;
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Offset 0 is the first negedge on which the start bit is visible.
    task automatic wait_start(input string name, output logic ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < 2000) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        cur_off = 0;
        chk({name, " start seen"}, {31'b0, ok}, 32'd1);
    endtask

    function automatic logic [7:0] byte_of(input int i);
        return 8'(i * 37 + 5);
    endfunction

    task automatic run_frame(input frame_vec_t v, input int div);
        logic ok;
        int   b;
        int   l;
        divisor      = DIV_W'(div);
        wls          = v.wls;
        pen          = v.pen;
        eps          = v.eps;
        stick_parity = v.stick;
        stb          = v.stb;
        write_byte(v.data);
        wait_start(v.name, ok);
        if (ok) begin
            // Frame config must be latched; disturb the inputs mid-frame.
            wls          = ~v.wls;
            pen          = ~v.pen;
            eps          = ~v.eps;
            stick_parity = ~v.stick;
            stb          = ~v.stb;
            b = OVS * div;
            for (int k = 0; k < v.nbits; k++) begin
                goto_off(k * b + b / 2);
                chk($sformatf("%s bit%0d", v.name, k), {31'b0, tx}, {31'b0, v.bits[k]});
            end
            goto_off(v.nbits * b + (v.stop_ticks * div) / 2);
            chk({v.name, " stop level"}, {31'b0, tx}, 32'd1);
            chk({v.name, " thre mid-stop"}, {31'b0, thre}, 32'd1);
            l = (v.nbits * OVS + v.stop_ticks) * div;
            goto_off(l - 1);
            chk({v.name, " tsre before end"}, {31'b0, tsre}, 32'd0);
            goto_off(l);
            chk({v.name, " tsre at end"}, {31'b0, tsre}, 32'd1);
        end
    endtask

    initial begin
        logic        ok;
        logic [31:0] ovf_mask;
        logic [9:0]  obs;
        logic [9:0]  expf;
        logic [7:0]  db;
        int          brk_bad;
        frame_vec_t  v;

        vecs[0] = '{"8E2 0x13",      2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 8'h13, 10, 12'h226, 32};
        vecs[1] = '{"5O1.5 0xFF",    2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF,  7, 12'h03E, 24};
        vecs[2] = '{"8 stick eps1",  2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 10, 12'h14A, 16};
        vecs[3] = '{"7 stick eps0",  2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 8'h80,  9, 12'h100, 16};
        vecs[4] = '{"8N1 0x5A",      2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A,  9, 12'h0B4, 16};
        vecs[5] = '{"6E2 0xC7",      2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC7,  8, 12'h08E, 32};
        vecs[6] = '{"7O1 0x03",      2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h03,  9, 12'h106, 16};

        // ---------------- reset state, writes ignored during reset --------
        divisor = DIV_W'(2);
        repeat (3) @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 8'hAA;
        @(negedge clk);
        chk("reset tx",    {31'b0, tx},   32'd1);
        chk("reset thre",  {31'b0, thre}, 32'd1);
        chk("reset tsre",  {31'b0, tsre}, 32'd1);
        chk("reset full",  {31'b0, full}, 32'd0);
        chk("reset level", 32'(level),    32'd0);
        chk("reset ovf",   {31'b0, ovf},  32'd0);
        wr_en = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        chk("level after reset with wr_en", 32'(level), 32'd0);
        chk("tx idle after reset", {31'b0, tx}, 32'd1);

        // ---------------- table-driven frames ------------------------------
        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i], 2);
        end

        // ---------------- overflow, push+pop at full, back-to-back --------
        divisor      = '0;
        wls          = 2'b11;
        pen          = 1'b0;
        eps          = 1'b0;
        stick_parity = 1'b0;
        stb          = 1'b0;
        @(negedge clk);
        ovf_mask = '0;
        for (int i = 0; i <= FIFO_DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_data = byte_of(i);
            @(negedge clk);
            if (ovf === 1'b1) ovf_mask[i] = 1'b1;
        end
        wr_en = 1'b0;
        @(negedge clk);
        chk("ovf single pulse on dropped write", ovf_mask, 32'(1) << FIFO_DEPTH);
        chk("ovf cleared next cycle", {31'b0, ovf}, 32'd0);
        chk("full after overflow", {31'b0, full}, 32'd1);
        chk("level at depth", 32'(level), 32'(FIFO_DEPTH));
        chk("thre when full", {31'b0, thre}, 32'd0);
        chk("tsre when full", {31'b0, tsre}, 32'd0);

        // Restart ticks while writing: pop and push land on the same edge.
        wr_en   = 1'b1;
        wr_data = byte_of(17);
        divisor = DIV_W'(1);
        @(negedge clk);
        wr_en   = 1'b0;
        cur_off = 0;
        chk("push+pop at full keeps level", 32'(level), 32'(FIFO_DEPTH));
        chk("push+pop at full no ovf", {31'b0, ovf}, 32'd0);
        chk("first start bit on pop", {31'b0, tx}, 32'd0);
        for (int f = 0; f <= FIFO_DEPTH; f++) begin
            db   = (f < FIFO_DEPTH) ? byte_of(f) : byte_of(17);
            expf = {1'b1, db, 1'b0};
            for (int k = 0; k < 10; k++) begin
                goto_off(f * 10 * OVS + k * OVS + OVS / 2);
                obs[k] = tx;
            end
            chk($sformatf("b2b frame%0d", f), 32'(obs), 32'(expf));
        end
        goto_off((FIFO_DEPTH + 1) * 10 * OVS - 1);
        chk("b2b tsre before end", {31'b0, tsre}, 32'd0);
        goto_off((FIFO_DEPTH + 1) * 10 * OVS);
        chk("b2b tsre at end", {31'b0, tsre}, 32'd1);

        // ---------------- break mid-DATA (8N1 0x5A, divisor 2) ------------
        divisor = DIV_W'(2);
        wls     = 2'b11;
        pen     = 1'b0;
        stb     = 1'b0;
        write_byte(8'h5A);
        wait_start("break", ok);
        if (ok) begin
            goto_off(2 * OVS + OVS);
            chk("break pre bit1", {31'b0, tx}, 32'd0);
            goto_off(4 * OVS + OVS);
            set_break = 1'b1;
            brk_bad   = 0;
            for (int n = 0; n < 4 * OVS; n++) begin
                goto_off(cur_off + 1);
                if (tx !== 1'b0) brk_bad++;
            end
            chk("break holds tx low", 32'(brk_bad), 32'd0);
            set_break = 1'b0;
            goto_off(cur_off + 1);
            chk("break release bit4", {31'b0, tx}, 32'd1);
            for (int k = 5; k < 9; k++) begin
                goto_off(k * 2 * OVS + OVS);
                chk($sformatf("break bit%0d", k), {31'b0, tx}, {31'b0, vecs[4].bits[k]});
            end
            goto_off(9 * 2 * OVS + OVS);
            chk("break stop", {31'b0, tx}, 32'd1);
            goto_off((9 * OVS + OVS) * 2 - 1);
            chk("break tsre before end", {31'b0, tsre}, 32'd0);
            goto_off((9 * OVS + OVS) * 2);
            chk("break tsre at end", {31'b0, tsre}, 32'd1);
        end

        // ---------------- reset mid-frame ----------------------------------
        divisor = '0;
        write_byte(8'h5A);
        write_byte(8'h33);
        divisor = DIV_W'(2);
        wait_start("rst mid", ok);
        if (ok) begin
            goto_off(3 * 2 * OVS + OVS);
            chk("rst mid pre level", 32'(level), 32'd1);
            chk("rst mid pre tx", {31'b0, tx}, 32'd0);
            rst     = 1'b1;
            wr_en   = 1'b1;
            wr_data = 8'hEE;
            #1;
            chk("rst mid tx",    {31'b0, tx},   32'd1);
            chk("rst mid thre",  {31'b0, thre}, 32'd1);
            chk("rst mid level", 32'(level),    32'd0);
            chk("rst mid tsre",  {31'b0, tsre}, 32'd1);
            @(negedge clk);
            chk("rst mid wr ignored", 32'(level), 32'd0);
            chk("rst mid ovf", {31'b0, ovf}, 32'd0);
            wr_en = 1'b0;
            rst   = 1'b0;
            @(negedge clk);
        end
        v      = vecs[0];
        v.name = "post-reset 8E2";
        run_frame(v, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
